// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and constants for the 8259A host sequencer
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_ACK1,
        ST_GAP,
        ST_ACK2
    } pic_state_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_INIT = 4;

    localparam logic A0_ICW1  = 1'b0;
    localparam logic A0_ICW_N = 1'b1;

    // Index of the final ICW write: ICW2 always, plus ICW3 in cascade mode, plus ICW4 when requested
    function automatic logic [1:0] icw_last_index(input logic [7:0] icw1_value);
        return 2'd1 + {1'b0, ~icw1_value[ICW1_SNGL]} + {1'b0, icw1_value[ICW1_IC4]};
    endfunction

endpackage

// File: rtl/pic_bus_timer.sv
// rtl/pic_bus_timer.sv - loadable down-counter with terminal-count flag
module pic_bus_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pic_host_sequencer.sv
// rtl/pic_host_sequencer.sv - CPU-side bus master sequencing 8259A init, commands and INTA cycles
module pic_host_sequencer
    import pic_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    output logic       init_busy,
    output logic       init_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       int_in,
    input  logic       ack_enable,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic [7:0] pic_d_out,
    output logic       pic_d_oe,
    input  logic [7:0] pic_d_in,
    output logic       pic_a0,
    output logic       pic_cs_n,
    output logic       pic_rd_n,
    output logic       pic_wr_n,
    output logic       pic_inta_n
);

    localparam int MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    pic_state_t      state;
    logic            cur_write;
    logic            cur_init;
    logic [3:0][7:0] init_words;
    logic [3:0][7:0] seq_words;
    logic [1:0]      init_idx;
    logic [1:0]      init_last;
    logic            ack_sel;
    logic            t_load;
    logic [CW-1:0]   t_value;
    logic            t_done;

    // Acknowledge wins over commands in IDLE; the vec_valid cycle is kept free of a new ACK1
    assign ack_sel   = (state == ST_IDLE) && int_in && ack_enable && !init_busy && !vec_valid;
    assign cmd_ready = !rst && (state == ST_IDLE) && !init_busy && !ack_sel;

    // Pack the ICW list so that skipped words leave no holes; ICW1 always carries the INIT bit
    always_comb begin
        seq_words = {icw4, icw3, icw2, icw1};
        seq_words[0][ICW1_INIT] = 1'b1;
        if (icw1[ICW1_SNGL]) begin
            seq_words[2] = icw4;
        end
    end

    // Timer reloads while outside a timed state and on the last cycle of each timed state
    always_comb begin
        t_load  = 1'b1;
        t_value = CW'(STROBE_CYCLES - 1);
        case (state)
            ST_STROBE, ST_GAP, ST_ACK2: t_load = t_done;
            ST_ACK1: begin
                t_load  = t_done;
                t_value = CW'(GAP_CYCLES - 1);
            end
            default: ;
        endcase
    end

    pic_bus_timer #(.WIDTH(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (t_load),
        .load_value (t_value),
        .done       (t_done)
    );

    // Main sequencer: bus strobes, init bookkeeping and pulse outputs, all registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pic_cs_n   <= 1'b1;
            pic_rd_n   <= 1'b1;
            pic_wr_n   <= 1'b1;
            pic_inta_n <= 1'b1;
            pic_d_oe   <= 1'b0;
            pic_a0     <= 1'b0;
            pic_d_out  <= 8'h00;
            init_busy  <= 1'b0;
            init_done  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'h00;
            vec_valid  <= 1'b0;
            vec_data   <= 8'h00;
            cur_write  <= 1'b0;
            cur_init   <= 1'b0;
            init_words <= '0;
            init_idx   <= 2'd0;
            init_last  <= 2'd0;
        end else begin
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            vec_valid <= 1'b0;

            if (init_start && !init_busy) begin
                init_busy  <= 1'b1;
                init_words <= seq_words;
                init_last  <= icw_last_index(icw1);
                init_idx   <= 2'd0;
            end

            case (state)
                ST_IDLE: begin
                    if (init_busy) begin
                        state     <= ST_SETUP;
                        pic_cs_n  <= 1'b0;
                        pic_a0    <= (init_idx == 2'd0) ? A0_ICW1 : A0_ICW_N;
                        pic_d_oe  <= 1'b1;
                        pic_d_out <= init_words[init_idx];
                        cur_write <= 1'b1;
                        cur_init  <= 1'b1;
                    end else if (ack_sel) begin
                        state      <= ST_ACK1;
                        pic_inta_n <= 1'b0;
                    end else if (cmd_valid) begin
                        state     <= ST_SETUP;
                        pic_cs_n  <= 1'b0;
                        pic_a0    <= cmd_a0;
                        cur_write <= cmd_write;
                        cur_init  <= 1'b0;
                        if (cmd_write) begin
                            pic_d_oe  <= 1'b1;
                            pic_d_out <= cmd_data;
                        end
                    end
                end
                ST_SETUP: begin
                    state <= ST_STROBE;
                    if (cur_write) begin
                        pic_wr_n <= 1'b0;
                    end else begin
                        pic_rd_n <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (t_done) begin
                        state    <= ST_HOLD;
                        pic_rd_n <= 1'b1;
                        pic_wr_n <= 1'b1;
                        if (!cur_write) begin
                            rsp_data  <= pic_d_in;
                            rsp_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    state    <= ST_IDLE;
                    pic_cs_n <= 1'b1;
                    pic_d_oe <= 1'b0;
                    if (cur_init) begin
                        if (init_idx == init_last) begin
                            init_done <= 1'b1;
                            init_busy <= 1'b0;
                            init_idx  <= 2'd0;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                ST_ACK1: begin
                    if (t_done) begin
                        state      <= ST_GAP;
                        pic_inta_n <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (t_done) begin
                        state      <= ST_ACK2;
                        pic_inta_n <= 1'b0;
                    end
                end
                ST_ACK2: begin
                    if (t_done) begin
                        state      <= ST_IDLE;
                        pic_inta_n <= 1'b1;
                        vec_data   <= pic_d_in;
                        vec_valid  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pic_host_sequencer.md
Name: pic_host_sequencer

Overview:
CPU-side bus master for the 8259A-compatible PIC. It generates the PIC's D/A0/CS_n/RD_n/WR_n/INTA_n strobes from clocked logic. It runs the ICW1..ICW4 initialization sequence and arbitrates single OCW-write/register-read commands against the two-pulse interrupt-acknowledge cycle. It captures the vector and presents it on a valid pulse.

Parameters:
STROBE_CYCLES, 2, cycles each RD_n/WR_n/INTA_n pulse stays low (>=1)
GAP_CYCLES, 1, cycles INTA_n is high between the two acknowledge pulses (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
init_start  in  1  one-cycle request to run ICW sequence
icw1 / icw2 / icw3 / icw4  in  8 each  ICW values sampled on accepted init_start
init_busy  out  1  high while ICW sequence pending or running
init_done  out  1  one-cycle pulse after last ICW write completes
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write (OCW), 0 = read (IRR/ISR/IMR)
cmd_a0  in  1  A0 for command
cmd_data  in  8  write data
rsp_valid  out  1  one-cycle pulse carrying read data
rsp_data  out  8  read data, held until next read
int_in  in  1  PIC INT output
ack_enable  in  1  permits INTA cycles
vec_valid  out  1  one-cycle pulse with captured vector
vec_data  out  8  vector sampled on second INTA pulse, held
pic_d_out  out  8  data driven to PIC
pic_d_oe  out  1  enables pic_d_out onto D
pic_d_in  in  8  data from PIC D
pic_a0 / pic_cs_n / pic_rd_n / pic_wr_n / pic_inta_n  out  1 each  PIC bus controls

Behaviour:
- Reset (async, immediate): pic_cs_n=pic_rd_n=pic_wr_n=pic_inta_n=1, pic_d_oe=0, pic_a0=0, pic_d_out=0, cmd_ready=0, init_busy=0, init_done=0, rsp_valid=0, vec_valid=0, rsp_data=0, vec_data=0. FSM to IDLE. Any pending init, command or ack is discarded; a bus cycle cut by reset is not resumed.
- FSM states: IDLE, SETUP, STROBE, HOLD (bus write/read); ACK1, GAP, ACK2 (acknowledge).
- Bus transaction:
  - SETUP 1 cycle: cs_n=0, a0 valid; for writes d_oe=1 and d_out valid.
  - STROBE STROBE_CYCLES cycles: rd_n or wr_n =0.
  - HOLD 1 cycle: strobe=1, cs_n=0, data/a0 held.
  - Then IDLE with cs_n=1, d_oe=0.
  - Reads sample pic_d_in on the last STROBE cycle. rsp_valid pulses in the HOLD cycle.
- Acknowledge cycle: cs_n=1, d_oe=0 throughout.
  - ACK1: inta_n=0 for STROBE_CYCLES.
  - GAP: inta_n=1 for GAP_CYCLES.
  - ACK2: inta_n=0 for STROBE_CYCLES; pic_d_in is sampled into vec_data on the last ACK2 cycle.
  - vec_valid pulses on the following cycle (back in IDLE).
- Init sequence: init_start accepted when init_busy=0; ignored while busy.
  - Writes in order: ICW1 (a0=0, bit4 forced to 1), ICW2 (a0=1).
  - Then ICW3 (a0=1) only if icw1[1]=0.
  - Then ICW4 (a0=1) only if icw1[0]=1.
  - One IDLE cycle between writes. init_done pulses the cycle after the final HOLD; init_busy falls the same cycle.
- init_start arriving mid command/ack: latched, init_busy=1 immediately, sequence starts when the FSM returns to IDLE.
- Arbitration in IDLE, highest first: pending init > acknowledge (int_in & ack_enable & not init_busy) > command.
- cmd_ready=1 only in IDLE with no pending init and no acknowledge selected that cycle.
- int_in is evaluated only in IDLE. After vec_valid, at least one IDLE cycle elapses before a new ACK1. int_in falling mid-acknowledge does not abort it.
- Internal counters sized $clog2(max(STROBE_CYCLES,GAP_CYCLES)+1), reload on state entry.

Decomposition:
- Shared package pic_pkg: FSM state enum, ICW1 bit indices (IC4=0, SNGL=1, INIT=4), A0 encodings.
- Sub-module pic_bus_timer: loadable down-counter with done flag, reused for strobe and gap timing.

Test Plan:
- init_start with icw1=0x11, icw2=0x20, icw3=0x04, icw4=0x01 -> four writes with a0=0,1,1,1 and data 0x11,0x20,0x04,0x01; each wr_n low 2 cycles; init_done pulses once.
- init_start with icw1=0x12 -> exactly two writes (ICW3, ICW4 skipped); icw1=0x02 -> ICW1 written as 0x12.
- cmd read a0=0 with pic_d_in=0x5A -> rd_n low 2 cycles, rsp_valid with rsp_data=0x5A, wr_n never low.
- int_in=1, ack_enable=1, cmd_valid=1 same cycle -> ACK chosen, cmd_ready=0; inta_n pattern low2/high1/low2 with cs_n=1; pic_d_in=0x23 on ACK2 -> vec_data=0x23, vec_valid one cycle; command executes afterwards.
- init_start during ACK2 -> ack completes, then ICW sequence runs; no acknowledge while init_busy even with int_in=1.
- rst asserted mid-STROBE of a write -> same-cycle wr_n=1, cs_n=1, d_oe=0; no rsp/vec/init_done pulse afterward.
